// File: rtl/atomic_exec_controller.sv
// Command sequencer for the atomic ALU datapath: owns the register file,
// drives the external ALU and performs write-back or compare-and-swap.
module atomic_exec_controller #(
  parameter int              DATA_W   = 32,
  parameter int              NUM_REGS = 8,
  parameter int              ADDR_W   = 3,
  parameter int              OP_W     = 3,
  parameter logic [OP_W-1:0] SUB_OP   = 3'b001
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [OP_W+3*ADDR_W-1:0]   cmd,
  input  logic                       ld_en,
  input  logic [ADDR_W-1:0]          ld_addr,
  input  logic [DATA_W-1:0]          ld_data,
  output logic [OP_W-1:0]            alu_op_code,
  output logic [DATA_W-1:0]          data_a,
  output logic [DATA_W-1:0]          data_b,
  input  logic [DATA_W-1:0]          y,
  input  logic                       Z,
  output logic                       done,
  output logic                       cas_success,
  output logic                       busy,
  input  logic [ADDR_W-1:0]          dbg_addr,
  output logic [DATA_W-1:0]          dbg_data
);

  localparam int CMD_W = OP_W + 3*ADDR_W;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DECODE     = 3'd1,
    EXECUTE    = 3'd2,
    WRITE_BACK = 3'd3,
    CAS_CMP    = 3'd4,
    CAS_SWAP   = 3'd5
  } state_t;

  state_t                 state_r;
  state_t                 state_s;
  logic [CMD_W-1:0]       cmd_r;
  logic [DATA_W-1:0]      regs_r [NUM_REGS];
  logic [DATA_W-1:0]      y_cap_r;
  logic                   z_cap_r;
  logic                   accept_s;
  logic                   done_s;
  logic [OP_W-1:0]        op_s;
  logic [ADDR_W-1:0]      ra_s;
  logic [ADDR_W-1:0]      rb_s;
  logic [ADDR_W-1:0]      rc_s;

  assign op_s = cmd_r[CMD_W-1 -: OP_W];
  assign ra_s = cmd_r[3*ADDR_W-1 -: ADDR_W];
  assign rb_s = cmd_r[2*ADDR_W-1 -: ADDR_W];
  assign rc_s = cmd_r[ADDR_W-1:0];

  assign dbg_data = regs_r[dbg_addr];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = DECODE;
        end else begin
          state_s = IDLE;
        end
      end
      DECODE: begin
        if (op_s == {OP_W{1'b1}}) begin
          state_s = CAS_CMP;
        end else begin
          state_s = EXECUTE;
        end
      end
      EXECUTE:    state_s = WRITE_BACK;
      WRITE_BACK: state_s = IDLE;
      CAS_CMP:    state_s = CAS_SWAP;
      CAS_SWAP:   state_s = IDLE;
      default:    state_s = IDLE;
    endcase
  end

  // Handshake and status decode
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    accept_s  = 1'b0;
    done_s    = 1'b0;
    if (state_r == IDLE) begin
      cmd_ready = 1'b1;
      busy      = 1'b0;
      accept_s  = cmd_valid;
    end else begin
      cmd_ready = 1'b0;
      busy      = 1'b1;
      accept_s  = 1'b0;
    end
    if ((state_s == WRITE_BACK) || (state_s == CAS_SWAP)) begin
      done_s = 1'b1;
    end else begin
      done_s = 1'b0;
    end
  end

  // Command latch, ALU drive, result capture and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_r       <= {CMD_W{1'b0}};
      alu_op_code <= {OP_W{1'b0}};
      data_a      <= {DATA_W{1'b0}};
      data_b      <= {DATA_W{1'b0}};
      y_cap_r     <= {DATA_W{1'b0}};
      z_cap_r     <= 1'b0;
      cas_success <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= done_s;
      if (accept_s) begin
        cmd_r <= cmd;
      end
      if (state_r == DECODE) begin
        data_a <= regs_r[ra_s];
        data_b <= regs_r[rb_s];
        if (op_s == {OP_W{1'b1}}) begin
          alu_op_code <= SUB_OP;
        end else begin
          alu_op_code <= op_s;
        end
      end
      if (state_r == EXECUTE) begin
        y_cap_r <= y;
      end
      // Success is visible during CAS_SWAP alongside done.
      if (state_r == CAS_CMP) begin
        z_cap_r     <= Z;
        cas_success <= Z;
      end
    end
  end

  // Register file: idle preload, write-back and atomic swap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if ((state_r == IDLE) && ld_en) begin
        regs_r[ld_addr] <= ld_data;
      end
      if (state_r == WRITE_BACK) begin
        regs_r[rc_s] <= y_cap_r;
      end
      // With ra==rc both writes carry the same old value, so it stays put.
      if ((state_r == CAS_SWAP) && z_cap_r) begin
        regs_r[ra_s] <= regs_r[rc_s];
        regs_r[rc_s] <= regs_r[ra_s];
      end
    end
  end

endmodule

// File: tb/tb_atomic_exec_controller.sv
// Scoreboard bench for atomic_exec_controller with a behavioural ALU.
module tb_atomic_exec_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [11:0] cmd;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [31:0] ld_data;
  logic [2:0]  alu_op_code;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic [31:0] y;
  logic        Z;
  logic        done;
  logic        cas_success;
  logic        busy;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        is_cas;
    logic        succ;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   done_count = 0;

  atomic_exec_controller dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_op_code(alu_op_code), .data_a(data_a), .data_b(data_b),
    .y(y), .Z(Z), .done(done), .cas_success(cas_success), .busy(busy),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // External ALU model
  always_comb begin
    case (alu_op_code)
      3'b000:  y = data_a + data_b;
      3'b001:  y = data_a - data_b;
      3'b010:  y = data_a & data_b;
      3'b011:  y = data_a | data_b;
      3'b100:  y = data_a ^ data_b;
      default: y = 32'd0;
    endcase
    Z = (y == 32'd0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding command
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      done_count++;
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done with empty queue expected none");
      end else begin
        e = q.pop_front();
        chk("mon_opcode", {29'd0, alu_op_code}, {29'd0, e.op});
        chk("mon_data_a", data_a, e.a);
        chk("mon_data_b", data_b, e.b);
        if (e.is_cas) begin
          chk("mon_cas_success", {31'd0, cas_success}, {31'd0, e.succ});
        end
      end
    end
  end

  task automatic preload(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    chk($sformatf("reg%0d", a), dbg_data, exp);
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb,
                         input logic [2:0] rc, input logic [31:0] ea, input logic [31:0] eb,
                         input logic es, input bit same_ld, input logic [2:0] la,
                         input logic [31:0] ld, input bit hold);
    exp_t e;
    int   w;
    int   d0;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd = {op, ra, rb, rc};
    if (same_ld) begin
      ld_en = 1'b1; ld_addr = la; ld_data = ld;
    end
    e.op = (op == 3'b111) ? 3'b001 : op;
    e.a = ea; e.b = eb; e.is_cas = (op == 3'b111); e.succ = es;
    q.push_back(e);
    d0 = done_count;
    @(negedge clk);  // T+1
    ld_en = 1'b0;
    if (hold) begin
      cmd = {3'b000, 3'd0, 3'd0, 3'd5};
      ld_en = 1'b1; ld_addr = 3'd5; ld_data = 32'hDEAD;
    end else begin
      cmd_valid = 1'b0;
    end
    chk("busy_t1", {31'd0, busy}, 32'd1);
    chk("ready_t1", {31'd0, cmd_ready}, 32'd0);
    chk("done_t1", {31'd0, done}, 32'd0);
    @(negedge clk);  // T+2
    chk("done_t2", {31'd0, done}, 32'd0);
    @(negedge clk);  // T+3
    chk("done_t3", {31'd0, done}, 32'd1);
    chk("busy_t3", {31'd0, busy}, 32'd1);
    if (hold) begin
      cmd_valid = 1'b0; ld_en = 1'b0;
    end
    @(negedge clk);  // T+4
    chk("ready_t4", {31'd0, cmd_ready}, 32'd1);
    chk("done_t4", {31'd0, done}, 32'd0);
    chk("one_done", done_count - d0, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd = 12'd0; ld_en = 1'b0;
    ld_addr = 3'd0; ld_data = 32'd0; dbg_addr = 3'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) rd(i[2:0], 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_cas", {31'd0, cas_success}, 32'd0);
    chk("rst_data_a", data_a, 32'd0);

    // ADD r4 = r1 + r2
    preload(3'd1, 32'd5); preload(3'd2, 32'd3);
    run_cmd(3'b000, 3'd1, 3'd2, 3'd4, 32'd5, 32'd3, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
    rd(3'd4, 32'd8);

    // SUB with r6 loaded on the accept edge
    run_cmd(3'b001, 3'd6, 3'd2, 3'd7, 32'd20, 32'd3, 1'b0, 1'b1, 3'd6, 32'd20, 1'b0);
    rd(3'd7, 32'd17); rd(3'd6, 32'd20);

    // CAS success: swap r0 and r2
    preload(3'd0, 32'd7); preload(3'd1, 32'd7); preload(3'd2, 32'd9);
    run_cmd(3'b111, 3'd0, 3'd1, 3'd2, 32'd7, 32'd7, 1'b1, 1'b0, 3'd0, 32'd0, 1'b0);
    rd(3'd0, 32'd9); rd(3'd1, 32'd7); rd(3'd2, 32'd7);
    chk("cas_hold", {31'd0, cas_success}, 32'd1);

    // CAS failure: no write
    preload(3'd0, 32'd7); preload(3'd1, 32'd6); preload(3'd2, 32'd9);
    run_cmd(3'b111, 3'd0, 3'd1, 3'd2, 32'd7, 32'd6, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
    rd(3'd0, 32'd7); rd(3'd1, 32'd6); rd(3'd2, 32'd9);
    chk("cas_fail_hold", {31'd0, cas_success}, 32'd0);

    // CAS with ra==rc
    preload(3'd3, 32'd4);
    run_cmd(3'b111, 3'd3, 3'd3, 3'd3, 32'd4, 32'd4, 1'b1, 1'b0, 3'd0, 32'd0, 1'b0);
    rd(3'd3, 32'd4);

    // XOR while cmd_valid and ld_en are held during busy
    run_cmd(3'b100, 3'd1, 3'd2, 3'd6, 32'd6, 32'd9, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
    rd(3'd6, 32'd15); rd(3'd5, 32'd0);
    repeat (6) @(negedge clk);
    chk("no_extra_done", done_count, 32'd6);

    // Reset during WRITE_BACK of ADD into r4
    preload(3'd1, 32'd5); preload(3'd2, 32'd3);
    @(negedge clk);
    cmd_valid = 1'b1; cmd = {3'b000, 3'd1, 3'd2, 3'd4};
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(3'd4, 32'd0);
    chk("rst_mid_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (5) @(negedge clk);
    chk("rst_mid_done_count", done_count, 32'd6);
    q.delete();

    chk("queue_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/atomic_exec_controller.md
Name: atomic_exec_controller

Overview:
- Parametrised command sequencer for the atomic ALU datapath.
- Owns a NUM_REGS x DATA_W register file and accepts commands through a valid/ready handshake.
- Drives the external combinational ALU and writes results back to a command-selected destination register.
- Supports an atomic compare-and-swap (CAS) that reports success and a done pulse per command.

Parameters:
- DATA_W, 32, register and ALU operand width
- NUM_REGS, 8, register-file depth (power of two, >=2)
- ADDR_W, 3, register address width; must equal log2(NUM_REGS)
- OP_W, 3, opcode width; the all-ones opcode is CAS
- SUB_OP, 3'b001, ALU opcode driven during the CAS compare

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd  in  OP_W+3*ADDR_W  {op, ra, rb, rc}, op in MSBs
- ld_en  in  1  register preload strobe
- ld_addr  in  ADDR_W  preload address
- ld_data  in  DATA_W  preload data
- alu_op_code  out  OP_W  opcode to ALU
- data_a  out  DATA_W  ALU operand A
- data_b  out  DATA_W  ALU operand B
- y  in  DATA_W  ALU result (combinational from alu_op_code/data_a/data_b)
- Z  in  1  ALU zero flag
- done  out  1  one-cycle pulse at command completion
- cas_success  out  1  result of the last CAS; valid with done
- busy  out  1  high in every state except IDLE
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  DATA_W  combinational read of registers[dbg_addr]

Behaviour:
- Reset (async assert, sync release), all to 0: state=IDLE, every register, alu_op_code, data_a, data_b, done, cas_success, captured result. No file-based initialisation.
- cmd_ready = (state==IDLE). A command is accepted on a clock edge with cmd_valid && cmd_ready; cmd is latched on that edge. cmd_valid while busy is ignored and produces no side effect.
- ld_en writes ld_data into registers[ld_addr] only when state==IDLE; it is ignored otherwise.
  - If a load and a command acceptance occur on the same edge, both take effect.
  - The command then reads the newly loaded value.
- States: IDLE, DECODE, EXECUTE, WRITE_BACK, CAS_CMP, CAS_SWAP.
  - IDLE -> DECODE on accept.
  - DECODE -> CAS_CMP if op is all-ones, else DECODE -> EXECUTE.
  - EXECUTE -> WRITE_BACK -> IDLE.
  - CAS_CMP -> CAS_SWAP -> IDLE.
- Operand drive: on the edge entering EXECUTE or CAS_CMP, register data_a=registers[ra] and data_b=registers[rb].
  - alu_op_code = op for EXECUTE, SUB_OP for CAS_CMP.
  - These outputs hold their value until the next command.
- Capture: on the edge leaving EXECUTE, y is stored. On the edge leaving CAS_CMP, Z is stored.
- WRITE_BACK: registers[rc] <= captured y. done=1 for this cycle.
- CAS_SWAP:
  - If captured Z=1: registers[ra] and registers[rc] exchange their pre-swap values atomically on one edge; ra==rc leaves the register unchanged. If Z=0, no write.
  - cas_success <= captured Z, held until the next CAS completes.
  - done=1 for this cycle.
- Latency: accept edge T, done high in cycle T+3, cmd_ready high again at T+4 (4-cycle throughput for both command types).
- Widths: y is written unmodified at DATA_W. No carry or overflow tracking.
- Reset mid-command aborts immediately: no partial write, no swap, done stays 0.

Test Plan:
- Reset then dbg_addr sweep 0..7 -> dbg_data=0 for all; cmd_ready=1, busy=0, done=0.
- Preload r1=5, r2=3; cmd {000,1,2,4} (ADD) -> alu_op_code=000, data_a=5, data_b=3 in EXECUTE; done at T+3; r4=8; cmd_ready back at T+4.
- Preload r0=7, r1=7, r2=9; CAS {111,0,1,2} -> alu_op_code=001 in CAS_CMP; Z=1; r0=9, r2=7, r1=7; cas_success=1 with done.
- Preload r0=7, r1=6, r2=9; CAS {111,0,1,2} -> Z=0; registers unchanged; cas_success=0.
- Hold cmd_valid high with a second command during busy -> ignored; exactly one done pulse; ld_en during busy leaves the register unchanged.
- Assert rst_n=0 in WRITE_BACK of ADD into r4 -> r4=0, done=0, state IDLE, cmd_ready=1 after release.
